// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory req/gnt + rvalid bus
interface instr_fetch_unit_if #(
  parameter int PC_WIDTH = 32
);
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_gnt;
  logic                imem_rvalid;
  logic [31:0]         imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and single-outstanding instruction fetcher
module instr_fetch_unit #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                start,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                flush,
  input  logic [PC_WIDTH-1:0] flush_pc,
  input  logic                end_process,
  input  logic                error_in,
  instr_fetch_unit_if.master  imem,
  output logic [31:0]         instr,
  output logic [6:0]          opCode,
  output logic [PC_WIDTH-1:0] pc,
  output logic                instr_valid,
  output logic                halted,
  output logic                fetch_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID,
    S_HALT
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         instr_q, instr_d;
  logic                squash_q, squash_d;
  logic                ferr_q, ferr_d;
  logic [PC_WIDTH-1:0] next_pc;

  function automatic logic misaligned(input logic [PC_WIDTH-1:0] a);
    return a[1:0] != 2'b00;
  endfunction

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      squash_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      squash_q <= squash_d;
      ferr_q   <= ferr_d;
    end
  end

  assign next_pc = redirect ? redirect_pc : pc_q + PC_WIDTH'(4);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    squash_d = squash_q;
    ferr_d   = ferr_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        // flush is deliberately ignored while stopped
        if (start) begin
          pc_d     = RESET_PC;
          ferr_d   = 1'b0;
          squash_d = 1'b0;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (flush) begin
          pc_d = flush_pc;
          if (misaligned(flush_pc)) begin
            ferr_d   = 1'b1;
            squash_d = 1'b0;
            state_d  = S_HALT;
          end else if (imem.imem_gnt) begin
            // the granted fetch was for the old address
            squash_d = 1'b1;
            state_d  = S_WAIT;
          end
        end else if (imem.imem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          pc_d = flush_pc;
          if (misaligned(flush_pc)) begin
            ferr_d   = 1'b1;
            squash_d = 1'b0;
            state_d  = S_HALT;
          end else if (imem.imem_rvalid) begin
            squash_d = 1'b0;
            state_d  = S_REQ;
          end else begin
            squash_d = 1'b1;
          end
        end else if (imem.imem_rvalid) begin
          if (squash_q) begin
            squash_d = 1'b0;
            state_d  = S_REQ;
          end else begin
            instr_d = imem.imem_rdata;
            state_d = S_VALID;
          end
        end
      end
      S_VALID: begin
        if (flush) begin
          instr_d = '0;
          pc_d    = flush_pc;
          if (misaligned(flush_pc)) begin
            ferr_d  = 1'b1;
            state_d = S_HALT;
          end else begin
            state_d = S_REQ;
          end
        end else if (error_in) begin
          ferr_d  = 1'b1;
          state_d = S_HALT;
        end else if (end_process) begin
          state_d = S_HALT;
        end else if (!stall) begin
          pc_d = next_pc;
          if (redirect && misaligned(redirect_pc)) begin
            ferr_d  = 1'b1;
            state_d = S_HALT;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign imem.imem_req  = (state_q == S_REQ);
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign opCode         = instr_q[6:0];
  assign pc             = pc_q;
  assign instr_valid    = (state_q == S_VALID);
  assign halted         = (state_q == S_HALT);
  assign fetch_error    = ferr_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed vector bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rstN, start, stall, redirect, flush, end_process, error_in;
  logic [31:0] redirect_pc, flush_pc;
  logic [31:0] instr;
  logic [6:0]  opCode;
  logic [31:0] pc;
  logic        instr_valid, halted, fetch_error;

  int errors = 0;
  int checks = 0;

  instr_fetch_unit_if #(.PC_WIDTH(32)) imem ();

  instr_fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rstN(rstN), .start(start), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .flush(flush), .flush_pc(flush_pc),
    .end_process(end_process), .error_in(error_in),
    .imem(imem.master),
    .instr(instr), .opCode(opCode), .pc(pc),
    .instr_valid(instr_valid), .halted(halted), .fetch_error(fetch_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, start, stall, redir;
    logic [31:0] rpc;
    logic        flush;
    logic [31:0] fpc;
    logic        endp, err, gnt, rv;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic        e_halt, e_ferr;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input logic rst_n, st, stl, rd, input logic [31:0] rpc,
                     input logic fl, input logic [31:0] fpc,
                     input logic ep, er, g, rv, input logic [31:0] rdat,
                     input logic ereq, input logic [31:0] eaddr, input logic ev,
                     input logic [31:0] ei, input logic eh, ef);
    vec_t v;
    v.rst_n = rst_n; v.start = st; v.stall = stl; v.redir = rd; v.rpc = rpc;
    v.flush = fl; v.fpc = fpc; v.endp = ep; v.err = er; v.gnt = g; v.rv = rv;
    v.rdata = rdat; v.e_req = ereq; v.e_addr = eaddr; v.e_valid = ev;
    v.e_instr = ei; v.e_halt = eh; v.e_ferr = ef;
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    rstN = 1'b1; start = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    flush = 1'b0; flush_pc = '0; end_process = 1'b0; error_in = 1'b0;
    imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_rdata = '0;
  endtask

  task automatic check_outs(input string name, input logic ereq, input logic [31:0] eaddr,
                            input logic ev, input logic [31:0] ei, input logic eh, ef);
    logic [127:0] act, exp;
    logic [6:0]   eop;
    eop = ei[6:0];
    act = {21'b0, imem.imem_req, imem.imem_addr, pc, instr_valid, instr, opCode, halted, fetch_error};
    exp = {21'b0, ereq, eaddr, eaddr, ev, ei, eop, eh, ef};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got req=%b addr=%h pc=%h valid=%b instr=%h op=%h halt=%b ferr=%b, want req=%b addr=%h valid=%b instr=%h halt=%b ferr=%b",
               name, imem.imem_req, imem.imem_addr, pc, instr_valid, instr, opCode, halted,
               fetch_error, ereq, eaddr, ev, ei, eh, ef);
    end
  endtask

  initial begin
    bit seen;
    drive_idle();
    rstN = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_outs("reset", 0, 32'h0, 0, 32'h0, 0, 0);

    //  rst st stl rd  rpc           fl fpc         ep er g rv rdata          | req addr          v instr          h f
    row(1, 1, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0);
    row(1, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 1, 0, 32'h0,        1, 32'h0,        0, 32'h0,        0, 0);
    row(1, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0, 1, 32'h13,       0, 32'h0,        0, 32'h0,        0, 0);
    row(1, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h13,       0, 0);
    row(1, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 1, 0, 32'h0,        1, 32'h4,        0, 32'h13,       0, 0);
    row(1, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0, 1, 32'h13,       0, 32'h4,        0, 32'h13,       0, 0);
    row(1, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0, 0, 32'h0,        0, 32'h4,        1, 32'h13,       0, 0);
    row(1, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 1, 0, 32'h0,        1, 32'h8,        0, 32'h13,       0, 0);
    row(1, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0, 1, 32'h13,       0, 32'h8,        0, 32'h13,       0, 0);
    row(1, 0, 0, 0, 32'h0,        1, 32'h10,  0, 0, 0, 0, 32'h0,        0, 32'h8,        1, 32'h13,       0, 0);
    row(1, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 1, 0, 32'h0,        1, 32'h10,       0, 32'h0,        0, 0);
    row(1, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0, 1, 32'h00A00093, 0, 32'h10,       0, 32'h0,        0, 0);
    row(1, 0, 1, 1, 32'h40,       0, 32'h0,   0, 0, 0, 0, 32'h0,        0, 32'h10,       1, 32'h00A00093, 0, 0);
    row(1, 0, 1, 1, 32'h40,       0, 32'h0,   0, 0, 0, 0, 32'h0,        0, 32'h10,       1, 32'h00A00093, 0, 0);
    row(1, 0, 1, 1, 32'h40,       0, 32'h0,   0, 0, 0, 0, 32'h0,        0, 32'h10,       1, 32'h00A00093, 0, 0);
    row(1, 0, 0, 1, 32'h40,       0, 32'h0,   0, 0, 0, 0, 32'h0,        0, 32'h10,       1, 32'h00A00093, 0, 0);
    row(1, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 1, 0, 32'h0,        1, 32'h40,       0, 32'h00A00093, 0, 0);
    row(1, 0, 0, 0, 32'h0,        1, 32'h80,  0, 0, 0, 0, 32'h0,        0, 32'h40,       0, 32'h00A00093, 0, 0);
    row(1, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0, 0, 32'h0,        0, 32'h80,       0, 32'h00A00093, 0, 0);
    row(1, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0, 1, 32'hDEADBEEF, 0, 32'h80,       0, 32'h00A00093, 0, 0);
    row(1, 0, 0, 0, 32'h0,        1, 32'hC0,  0, 0, 1, 0, 32'h0,        1, 32'h80,       0, 32'h00A00093, 0, 0);
    row(1, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0, 1, 32'hDEADBEEF, 0, 32'hC0,       0, 32'h00A00093, 0, 0);
    row(1, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 1, 0, 32'h0,        1, 32'hC0,       0, 32'h00A00093, 0, 0);
    row(1, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0, 1, 32'h13,       0, 32'hC0,       0, 32'h00A00093, 0, 0);
    row(1, 0, 0, 0, 32'h0,        0, 32'h0,   0, 1, 0, 0, 32'h0,        0, 32'hC0,       1, 32'h13,       0, 0);
    row(1, 0, 0, 0, 32'h0,        1, 32'h200, 0, 0, 0, 0, 32'h0,        0, 32'hC0,       0, 32'h13,       1, 1);
    row(1, 1, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0, 1, 32'hDEADBEEF, 0, 32'hC0,       0, 32'h13,       1, 1);
    row(1, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 1, 0, 32'h0,        1, 32'h0,        0, 32'h13,       0, 0);
    row(1, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0, 1, 32'h13,       0, 32'h0,        0, 32'h13,       0, 0);
    row(1, 0, 0, 1, 32'h42,       0, 32'h0,   0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h13,       0, 0);
    row(1, 1, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0, 0, 32'h0,        0, 32'h42,       0, 32'h13,       1, 1);
    row(1, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 1, 0, 32'h0,        1, 32'h0,        0, 32'h13,       0, 0);
    row(1, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0, 1, 32'h13,       0, 32'h0,        0, 32'h13,       0, 0);
    row(1, 0, 0, 1, 32'hFFFFFFFC, 0, 32'h0,   0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h13,       0, 0);
    row(1, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 1, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 32'h13,       0, 0);
    row(1, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0, 1, 32'h73,       0, 32'hFFFFFFFC, 0, 32'h13,       0, 0);
    row(1, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0, 0, 32'h0,        0, 32'hFFFFFFFC, 1, 32'h73,       0, 0);
    row(1, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 1, 0, 32'h0,        1, 32'h0,        0, 32'h73,       0, 0);
    row(1, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0, 1, 32'h13,       0, 32'h0,        0, 32'h73,       0, 0);
    row(1, 0, 1, 0, 32'h0,        0, 32'h0,   1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h13,       0, 0);
    row(1, 1, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h13,       1, 0);
    row(1, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 1, 0, 32'h0,        1, 32'h0,        0, 32'h13,       0, 0);
    row(0, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h13,       0, 0);
    row(1, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0, 1, 32'hDEADBEEF, 0, 32'h0,        0, 32'h0,        0, 0);
    row(1, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0);

    foreach (vecs[i]) begin
      rstN = vecs[i].rst_n; start = vecs[i].start; stall = vecs[i].stall;
      redirect = vecs[i].redir; redirect_pc = vecs[i].rpc;
      flush = vecs[i].flush; flush_pc = vecs[i].fpc;
      end_process = vecs[i].endp; error_in = vecs[i].err;
      imem.imem_gnt = vecs[i].gnt; imem.imem_rvalid = vecs[i].rv; imem.imem_rdata = vecs[i].rdata;
      #1 check_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                    vecs[i].e_instr, vecs[i].e_halt, vecs[i].e_ferr);
      @(negedge clk);
    end

    // slow memory: grant after two idle request cycles, data two cycles after grant
    drive_idle();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) begin
      #1 check_outs("req_wait_gnt", 1, 32'h0, 0, 32'h0, 0, 0);
      @(negedge clk);
    end
    imem.imem_gnt = 1'b1;
    @(negedge clk);
    imem.imem_gnt = 1'b0;
    @(negedge clk);
    imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'h00000513;
    @(negedge clk);
    imem.imem_rvalid = 1'b0; imem.imem_rdata = '0;
    seen = 1'b0;
    for (int n = 0; n < 8 && !seen; n++) begin
      #1 if (instr_valid) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL slow_valid_timeout: instr_valid=%b want 1 within 8 cycles", instr_valid);
    end
    check_outs("slow_valid", 0, 32'h0, 1, 32'h00000513, 0, 0);

    // misaligned flush target from VALID halts with the target as pc
    flush = 1'b1; flush_pc = 32'h6;
    @(negedge clk);
    flush = 1'b0; flush_pc = '0;
    #1 check_outs("flush_misaligned", 0, 32'h6, 0, 32'h0, 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
